// File: rtl/ncut_if_stage_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : ncut_if_stage_pkg                                              |
// | Brief   : Shared constants for the NCUT MiniSys instruction-fetch stage. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ncut_if_stage_pkg;

  localparam logic        c_rst_enable  = 1'b0;
  localparam logic        c_rst_disable = 1'b1;
  localparam logic [31:0] c_zero_word   = 32'h0000_0000;
  localparam logic [31:0] c_nop_inst    = 32'h0000_0000;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_en_e;

endpackage

`default_nettype wire

// File: rtl/ncut_pc_reg.sv
// +--------------------------------------------------------------------------+
// | Module  : ncut_pc_reg                                                    |
// | Brief   : Fetch PC register with ROM chip enable and redirect priority.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ncut_pc_reg
  import ncut_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o
);

  chip_en_e          r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  // ce rises on the first edge after release, so the first fetch is RESET_PC itself
  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_rst_enable) begin
      r_ce <= CHIP_DISABLE;
    end else begin
      r_ce <= CHIP_ENABLE;
    end
  end

  always_comb begin
    w_pc_next = r_pc + ADDR_W'(4);
    if (flush) begin
      w_pc_next = new_pc;
    end else if (stall_if) begin
      w_pc_next = r_pc;
    end else if (branch_flag_i) begin
      w_pc_next = branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_rst_enable) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (r_ce == CHIP_ENABLE) begin
      r_pc <= w_pc_next;
    end
  end

  assign pc_o = r_pc;
  assign ce_o = (r_ce == CHIP_ENABLE);

endmodule

`default_nettype wire

// File: rtl/ncut_if_stage.sv
// +--------------------------------------------------------------------------+
// | Module  : ncut_if_stage                                                  |
// | Brief   : IF front end: PC register, ROM strobe and IF/ID pipe register. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ncut_if_stage
  import ncut_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  logic [ADDR_W-1:0] w_pc;
  logic              w_ce;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_id_valid;

  ncut_pc_reg #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (ADDR_W)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_if),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_o            (w_pc),
    .ce_o            (w_ce)
  );

  // A disabled ROM yields no instruction, so that cycle enters IF/ID as a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_rst_enable) begin
      r_id_pc    <= '0;
      r_id_inst  <= INST_W'(c_nop_inst);
      r_id_valid <= 1'b0;
    end else if (flush || !w_ce) begin
      r_id_pc    <= '0;
      r_id_inst  <= INST_W'(c_nop_inst);
      r_id_valid <= 1'b0;
    end else if (stall_id) begin
      r_id_pc    <= r_id_pc;
      r_id_inst  <= r_id_inst;
      r_id_valid <= r_id_valid;
    end else if (stall_if) begin
      r_id_pc    <= '0;
      r_id_inst  <= INST_W'(c_nop_inst);
      r_id_valid <= 1'b0;
    end else begin
      r_id_pc    <= w_pc;
      r_id_inst  <= inst_i;
      r_id_valid <= w_ce;
    end
  end

  assign pc_o       = w_pc;
  assign ce_o       = w_ce;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;
  assign id_valid_o = r_id_valid;

endmodule

`default_nettype wire

// File: tb/tb_ncut_if_stage.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_ncut_if_stage                                               |
// | Brief   : Directed vector bench for the NCUT instruction-fetch stage.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ncut_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        sif;
    logic        sid;
    logic        fl;
    logic [31:0] npc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_id_pc;
    logic        e_valid;
  } vec_t;

  vec_t vecs [19];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign inst_i = rom(pc_o);

  ncut_if_stage #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32),
    .INST_W   (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_i          (inst_i),
    .pc_o            (pc_o),
    .ce_o            (ce_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o)
  );

  always @(posedge clk) begin
    if (rst && stall_id && !stall_if)
      $display("NOTE: illegal ctrl encoding stall_id=1 stall_if=0 at %0t", $time);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_ce,
                           input logic [31:0] e_id_pc, input logic e_valid);
    chk({tag, " pc_o"}, pc_o, e_pc);
    chk({tag, " ce_o"}, {31'b0, ce_o}, {31'b0, e_ce});
    chk({tag, " id_pc_o"}, id_pc_o, e_id_pc);
    chk({tag, " id_inst_o"}, id_inst_o, e_valid ? rom(e_id_pc) : 32'h0);
    chk({tag, " id_valid_o"}, {31'b0, id_valid_o}, {31'b0, e_valid});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sif   sid   fl    new_pc        br    target        exp pc        exp id_pc     valid
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      32'h0000_0100, 32'h0000_0008, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       32'h0000_0010, 32'h0000_0100, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0100, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0100, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0100, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0014, 32'h0000_0010, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      32'h0000_0014, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h20,       1'b1, 32'h300,      32'h0000_0020, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0024, 32'h0000_0020, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0024, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h40,       1'b1, 32'h500,      32'h0000_0040, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0044, 32'h0000_0040, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0048, 32'h0000_0040, 1'b1};

    // Reset held for two cycles, checked while asserted
    @(posedge clk); @(posedge clk); #1;
    chk_state("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      stall_if        = vecs[i].sif;
      stall_id        = vecs[i].sid;
      flush           = vecs[i].fl;
      new_pc          = vecs[i].npc;
      branch_flag_i   = vecs[i].br;
      branch_target_i = vecs[i].tgt;
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_pc, 1'b1, vecs[i].e_id_pc, vecs[i].e_valid);
      @(negedge clk);
    end

    stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0; branch_flag_i = 1'b0;

    // Mid-cycle asynchronous reset: outputs clear without waiting for an edge
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_state("restart1", 32'h0, 1'b1, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk_state("restart2", 32'h4, 1'b1, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk_state("restart3", 32'h8, 1'b1, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
